// File: rtl/fetch_refill_ctrl.sv
// Instruction-miss refill sequencer: stalls fetch, bursts a line from the memory bus into the I-mem fill port.
// Optional build macro REFILL_CRITICAL_WORD_FIRST_EN starts the burst at the missed word and wraps within the line.
module fetch_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Imiss,
    input  logic [ADDR_W-1:0] MissAddr,
    output logic              FetchStall,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemGnt,
    input  logic              MemRValid,
    input  logic [DATA_W-1:0] MemRData,
    output logic              FillWe,
    output logic [ADDR_W-1:0] FillAddr,
    output logic [DATA_W-1:0] FillData,
    output logic              FillDone,
    output logic [31:0]       MissCount
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                    state_r;
    logic [IDX_W-1:0]          beat_r;
    logic [ADDR_W-OFF_W-1:0]   line_r;
    logic                      mem_req_r;
    logic [ADDR_W-1:0]         mem_addr_r;
    logic                      fill_done_r;
    logic [31:0]               miss_count_r;
    logic [ADDR_W-1:0]         start_addr_s;
    logic [IDX_W-1:0]          fill_word_s;
    logic                      fill_we_s;
    logic                      unused_s;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    logic [IDX_W-1:0]          idx_r;

    assign start_addr_s = {MissAddr[ADDR_W-1:2], 2'b00};
    assign fill_word_s  = idx_r + beat_r;
    assign unused_s     = ^MissAddr[1:0];

    // Missed word index, only needed to rotate the fill order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            idx_r <= {IDX_W{1'b0}};
        end else if ((state_r == ST_IDLE) && Imiss) begin
            idx_r <= MissAddr[OFF_W-1:2];
        end else begin
            idx_r <= idx_r;
        end
    end
`else
    assign start_addr_s = {MissAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign fill_word_s  = beat_r;
    assign unused_s     = ^MissAddr[OFF_W-1:0];
`endif

    // Refill sequencer with registered bus request, address, completion pulse and counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r      <= ST_IDLE;
            beat_r       <= {IDX_W{1'b0}};
            line_r       <= {(ADDR_W-OFF_W){1'b0}};
            mem_req_r    <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            fill_done_r  <= 1'b0;
            miss_count_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    fill_done_r <= 1'b0;
                    if (Imiss) begin
                        line_r     <= MissAddr[ADDR_W-1:OFF_W];
                        mem_addr_r <= start_addr_s;
                        mem_req_r  <= 1'b1;
                        state_r    <= ST_REQ;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (MemGnt) begin
                        mem_req_r <= 1'b0;
                        beat_r    <= {IDX_W{1'b0}};
                        state_r   <= ST_BURST;
                    end else begin
                        state_r   <= ST_REQ;
                    end
                end
                ST_BURST: begin
                    if (MemRValid) begin
                        // Counter wraps to zero naturally on the last beat.
                        beat_r <= beat_r + IDX_W'(1);
                        if (beat_r == LAST_BEAT) begin
                            fill_done_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            state_r     <= ST_BURST;
                        end
                    end else begin
                        state_r <= ST_BURST;
                    end
                end
                ST_DONE: begin
                    fill_done_r <= 1'b0;
                    if (miss_count_r != 32'hFFFF_FFFF) begin
                        miss_count_r <= miss_count_r + 32'd1;
                    end else begin
                        miss_count_r <= miss_count_r;
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    mem_req_r   <= 1'b0;
                    fill_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Fill port follows the read beat in the same cycle; zero whenever not writing.
    always_comb begin
        fill_we_s = 1'b0;
        FillAddr  = {ADDR_W{1'b0}};
        FillData  = {DATA_W{1'b0}};
        if (!Rst && (state_r == ST_BURST) && MemRValid) begin
            fill_we_s = 1'b1;
            FillAddr  = {line_r, fill_word_s, 2'b00};
            FillData  = MemRData;
        end else begin
            fill_we_s = 1'b0;
        end
    end

    assign FillWe     = fill_we_s;
    assign FetchStall = Imiss | (state_r != ST_IDLE);
    assign MemReq     = mem_req_r;
    assign MemAddr    = mem_addr_r;
    assign FillDone   = fill_done_r;
    assign MissCount  = miss_count_r;

endmodule

// File: tb/tb_fetch_refill_ctrl.sv
// Randomized self-checking bench for fetch_refill_ctrl against an address/ordering model of the refill.
module tb_fetch_refill_ctrl;

    localparam int LW = 4;

    logic        Clk;
    logic        Rst;
    logic        Imiss;
    logic [31:0] MissAddr;
    logic        FetchStall;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemGnt;
    logic        MemRValid;
    logic [31:0] MemRData;
    logic        FillWe;
    logic [31:0] FillAddr;
    logic [31:0] FillData;
    logic        FillDone;
    logic [31:0] MissCount;

    int checks;
    int errors;
    int model_cnt;

    fetch_refill_ctrl #(.LINE_WORDS(LW), .ADDR_W(32), .DATA_W(32)) dut (
        .Clk(Clk), .Rst(Rst), .Imiss(Imiss), .MissAddr(MissAddr),
        .FetchStall(FetchStall), .MemReq(MemReq), .MemAddr(MemAddr),
        .MemGnt(MemGnt), .MemRValid(MemRValid), .MemRData(MemRData),
        .FillWe(FillWe), .FillAddr(FillAddr), .FillData(FillData),
        .FillDone(FillDone), .MissCount(MissCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Rst = 1'b1; Imiss = 1'b0; MissAddr = 32'd0; MemGnt = 1'b0;
        MemRValid = 1'b0; MemRData = 32'd0;
        step();
        step();
        Rst = 1'b0;
        model_cnt = 0;
    endtask

    // One full refill: Imiss cycle, REQ with a given grant delay, burst with pattern or random gaps, DONE.
    task automatic do_refill(input logic [31:0] addr, input int gnt_delay, input logic [15:0] pat,
                             input int pat_len, input bit fixed_data, input bit noise);
        logic [31:0] base, exp_mem, exp_fa, dat;
        int idx, k, cyc;
        bit v;
        base = addr & ~(32'(LW * 4) - 32'd1);
        idx  = int'((addr >> 2) % LW);
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
        exp_mem = base + 32'(4 * idx);
`else
        exp_mem = base;
        idx = 0;
`endif
        Imiss = 1'b1; MissAddr = addr;
        MemGnt = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        MemRValid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge Clk);
        checks++; if (FetchStall !== 1'b1) begin errors++; $display("FAIL miss_stall: got %b expected 1", FetchStall); end
        checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", MemReq); end
        checks++; if (FillWe !== 1'b0) begin errors++; $display("FAIL idle_we: got %b expected 0", FillWe); end
        step();
        for (int d = 0; d <= gnt_delay; d++) begin
            Imiss = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            MissAddr = $urandom;
            MemGnt = (d == gnt_delay);
            MemRValid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge Clk);
            checks++; if (MemReq !== 1'b1) begin errors++; $display("FAIL req: got %b expected 1", MemReq); end
            checks++; if (MemAddr !== exp_mem) begin errors++; $display("FAIL mem_addr: got %h expected %h", MemAddr, exp_mem); end
            checks++; if (FillWe !== 1'b0) begin errors++; $display("FAIL req_we: got %b expected 0", FillWe); end
            checks++; if (FetchStall !== 1'b1) begin errors++; $display("FAIL req_stall: got %b expected 1", FetchStall); end
            step();
        end
        k = 0;
        cyc = 0;
        while (k < LW && cyc < 200) begin
            if (pat_len > 0) v = (cyc < pat_len) ? pat[cyc] : 1'b1;
            else v = ($urandom_range(0, 2) != 0);
            dat = fixed_data ? (32'hA0 + 32'(k)) : $urandom;
            MemRValid = v; MemRData = dat;
            MemGnt = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            Imiss = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            exp_fa = base + 32'(4 * ((idx + k) % LW));
            @(negedge Clk);
            checks++; if (FetchStall !== 1'b1) begin errors++; $display("FAIL burst_stall: got %b expected 1", FetchStall); end
            checks++; if (FillDone !== 1'b0) begin errors++; $display("FAIL burst_done: got %b expected 0", FillDone); end
            checks++; if (FillWe !== v) begin errors++; $display("FAIL fill_we cyc %0d: got %b expected %b", cyc, FillWe, v); end
            if (v) begin
                checks++; if (FillAddr !== exp_fa) begin errors++; $display("FAIL fill_addr beat %0d: got %h expected %h", k, FillAddr, exp_fa); end
                checks++; if (FillData !== dat) begin errors++; $display("FAIL fill_data beat %0d: got %h expected %h", k, FillData, dat); end
            end
            step();
            if (v) k++;
            cyc++;
        end
        checks++; if (k != LW) begin errors++; $display("FAIL burst_timeout: got %0d beats expected %0d", k, LW); end
        MemRValid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        MemGnt = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        Imiss = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge Clk);
        checks++; if (FillDone !== 1'b1) begin errors++; $display("FAIL fill_done: got %b expected 1", FillDone); end
        checks++; if (FillWe !== 1'b0) begin errors++; $display("FAIL done_we: got %b expected 0", FillWe); end
        checks++; if (FetchStall !== 1'b1) begin errors++; $display("FAIL done_stall: got %b expected 1", FetchStall); end
        checks++; if (MissCount !== 32'(model_cnt)) begin errors++; $display("FAIL done_count: got %0d expected %0d", MissCount, model_cnt); end
        step();
        model_cnt++;
        Imiss = 1'b0; MemRValid = 1'b0; MemGnt = 1'b0;
    endtask

    // Quiet IDLE cycle with stray bus activity that must be ignored.
    task automatic check_idle();
        Imiss = 1'b0;
        MemRValid = 1'($urandom_range(0, 1));
        MemGnt = 1'($urandom_range(0, 1));
        MemRData = $urandom;
        @(negedge Clk);
        checks++; if (FetchStall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b expected 0", FetchStall); end
        checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL idle_memreq: got %b expected 0", MemReq); end
        checks++; if (FillWe !== 1'b0) begin errors++; $display("FAIL idle_fillwe: got %b expected 0", FillWe); end
        checks++; if (FillDone !== 1'b0) begin errors++; $display("FAIL idle_done: got %b expected 0", FillDone); end
        checks++; if (MissCount !== 32'(model_cnt)) begin errors++; $display("FAIL idle_count: got %0d expected %0d", MissCount, model_cnt); end
        step();
        MemRValid = 1'b0; MemGnt = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge Clk);
        checks++; if (FetchStall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", FetchStall); end
        checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", MemReq); end
        checks++; if (MemAddr !== 32'd0) begin errors++; $display("FAIL rst_memaddr: got %h expected 0", MemAddr); end
        checks++; if (FillWe !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", FillWe); end
        checks++; if (FillAddr !== 32'd0) begin errors++; $display("FAIL rst_filladdr: got %h expected 0", FillAddr); end
        checks++; if (FillData !== 32'd0) begin errors++; $display("FAIL rst_filldata: got %h expected 0", FillData); end
        checks++; if (FillDone !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", FillDone); end
        checks++; if (MissCount !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", MissCount); end
        step();
    endtask

    task automatic test_reset_mid_burst();
        Imiss = 1'b1; MissAddr = 32'h0000_0048;
        step();
        Imiss = 1'b0; MemGnt = 1'b1;
        step();
        MemGnt = 1'b0;
        for (int b = 0; b < 2; b++) begin
            MemRValid = 1'b1; MemRData = $urandom;
            @(negedge Clk);
            checks++; if (FillWe !== 1'b1) begin errors++; $display("FAIL mid_we beat %0d: got %b expected 1", b, FillWe); end
            step();
        end
        Rst = 1'b1; MemRValid = 1'b1;
        @(negedge Clk);
        checks++; if (FillWe !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %b expected 0", FillWe); end
        step();
        Rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            MemRValid = 1'b1; MemRData = $urandom;
            @(negedge Clk);
            checks++; if (FillWe !== 1'b0) begin errors++; $display("FAIL stray_we: got %b expected 0", FillWe); end
            checks++; if (FetchStall !== 1'b0) begin errors++; $display("FAIL stray_stall: got %b expected 0", FetchStall); end
            checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL stray_req: got %b expected 0", MemReq); end
            checks++; if (MissCount !== 32'd0) begin errors++; $display("FAIL stray_count: got %0d expected 0", MissCount); end
            step();
        end
        MemRValid = 1'b0;
        model_cnt = 0;
    endtask

    task automatic test_basic();
        do_refill(32'h0000_0048, 2, 16'hFFFF, 16, 1'b1, 1'b0);
        check_idle();
    endtask

    task automatic test_gapped();
        do_refill(32'h0000_0048, 2, 16'h0059, 7, 1'b1, 1'b0);
        check_idle();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_refill(32'h0000_0048, 1, 16'hFFFF, 16, 1'b0, 1'b0);
        do_refill(32'h0000_0080, 0, 16'hFFFF, 16, 1'b0, 1'b0);
        check_idle();
        checks++; if (model_cnt != 2) begin errors++; $display("FAIL b2b_model: got %0d expected 2", model_cnt); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            do_refill($urandom, $urandom_range(0, 4), 16'h0000, 0, 1'b0, 1'b1);
            if ($urandom_range(0, 1) == 1) check_idle();
        end
        check_idle();
    endtask

    initial begin
        checks = 0; errors = 0; model_cnt = 0;
        Rst = 1'b1; Imiss = 1'b0; MissAddr = 32'd0; MemGnt = 1'b0;
        MemRValid = 1'b0; MemRData = 32'd0;
        test_reset();
        test_reset_mid_burst();
        test_basic();
        test_gapped();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
